// File: rtl/i2s_pkg.sv
// ---------------------------------------------------------------------------
// i2s_pkg
// Shared constants and types for the I2S receive path.
//   I2S_FRAME_BITS : SCK periods in one stereo frame
//   I2S_POSN_W     : width of the frame position count
//   I2S_HALF       : SCK periods per channel half (ws low = left, ws high = right)
//   i2sState_e     : frame-alignment state of the stereo receiver
//   nextPosn()     : frame position that should follow a given one
// ---------------------------------------------------------------------------
package i2s_pkg;

   localparam int I2S_FRAME_BITS = 64;
   localparam int I2S_POSN_W     = 6;
   localparam int I2S_HALF       = 32;

   typedef enum logic [1:0] {
      SYNC      = 2'd0,
      LEFT      = 2'd1,
      RIGHT     = 2'd2,
      SYNC_WAIT = 2'd3
   } i2sState_e;

   // The position count wraps at the frame length, so the successor of the
   // last position is position 0 of the next frame.
   function automatic logic [I2S_POSN_W-1:0] nextPosn(input logic [I2S_POSN_W-1:0] posn);
      return I2S_POSN_W'((int'(posn) + 1) % I2S_FRAME_BITS);
   endfunction

endpackage

// File: rtl/i2s_shift_in.sv
// ---------------------------------------------------------------------------
// i2s_shift_in
// MSB-first serial-to-parallel shift register for one audio channel.
//   ck    : system clock
//   rst   : synchronous active-high reset, clears the register
//   clr   : discard the collected bits (may coincide with shift)
//   shift : take d as the new LSB, older bits move up one place
//   d     : serial data bit
//   q     : collected word, most recent bit in q[0]
// ---------------------------------------------------------------------------
module i2s_shift_in #(
   parameter int WIDTH = 24
) (
   input  logic             ck,
   input  logic             rst,
   input  logic             clr,
   input  logic             shift,
   input  logic             d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] shreg_q;
   logic [WIDTH-1:0] shreg_d;

   // Next contents. A clear together with a shift starts a fresh word whose
   // only bit is d, which is how a new frame captures its MSB while the
   // leftovers of the previous (or abandoned) frame are thrown away.
   always_comb begin
      shreg_d = shreg_q;
      if (clr) begin
         shreg_d = shift ? WIDTH'(d) : '0;
      end else if (shift) begin
         shreg_d = {shreg_q[WIDTH-2:0], d};
      end
   end

   // Register with synchronous reset.
   always_ff @(posedge ck) begin
      if (rst) begin
         shreg_q <= '0;
      end else begin
         shreg_q <= shreg_d;
      end
   end

   assign q = shreg_q;

endmodule

// File: rtl/i2s_stereo_rx.sv
// ---------------------------------------------------------------------------
// i2s_stereo_rx
// Deserialises one I2S data line into left/right sample pairs, realigning to
// the frame after reset or whenever the frame position jumps.
//   ck         : system clock
//   rst        : synchronous active-high reset
//   en         : one-cycle strobe per SCK period; all frame logic advances on it
//   frame_posn : bit position 0..63 in the frame (0..31 left half, 32..63 right)
//   sd         : serial data, already synchronous to ck
//   left/right : presented sample pair, changes only when a new pair is loaded
//   valid      : a pair is presented
//   ready      : consumer accepts the pair when valid && ready
//   overrun    : one-cycle pulse when a completed pair had to be dropped
//   resync     : one-cycle pulse when a partial frame is discarded
// ---------------------------------------------------------------------------
module i2s_stereo_rx
   import i2s_pkg::*;
#(
   parameter int WIDTH = 24
) (
   input  logic                  ck,
   input  logic                  rst,
   input  logic                  en,
   input  logic [I2S_POSN_W-1:0] frame_posn,
   input  logic                  sd,
   output logic [WIDTH-1:0]      left,
   output logic [WIDTH-1:0]      right,
   output logic                  valid,
   input  logic                  ready,
   output logic                  overrun,
   output logic                  resync
);

   localparam logic [I2S_POSN_W-1:0] WIDTH_P     = I2S_POSN_W'(WIDTH);
   localparam logic [I2S_POSN_W-1:0] LAST_IDX    = I2S_POSN_W'(WIDTH - 1);
   localparam logic [I2S_POSN_W-1:0] POSN_ONE    = I2S_POSN_W'(1);
   localparam logic [I2S_POSN_W-1:0] RIGHT_FIRST = I2S_POSN_W'(I2S_HALF + 1);

   i2sState_e             state_q, state_d;
   logic [I2S_POSN_W-1:0] expectPosn_q, expectPosn_d;
   logic                  seenEn_q, seenEn_d;
   logic                  valid_q, valid_d;
   logic                  overrun_q, overrun_d;
   logic                  resync_q, resync_d;
   logic [WIDTH-1:0]      leftOut_q, leftOut_d;
   logic [WIDTH-1:0]      rightOut_q, rightOut_d;

   logic [I2S_POSN_W-1:0] leftIdx;
   logic [I2S_POSN_W-1:0] rightIdx;
   logic                  discont;
   logic                  lostAlign;
   logic                  startFrame;
   logic                  leftShift;
   logic                  leftDone;
   logic                  rightShift;
   logic                  rightDone;
   logic                  shiftClr;
   logic                  loadPair;
   logic [WIDTH-1:0]      leftWord;
   logic [WIDTH-1:0]      rightWord;

   // Bit index within each channel. I2S delays data by one SCK, so left bit k
   // sits at position 1+k and right bit k at 33+k; the modulo-64 subtraction
   // makes a WIDTH=32 right LSB at position 0 come out as index 31, and any
   // position outside a channel comes out as an index >= WIDTH.
   assign leftIdx  = frame_posn - POSN_ONE;
   assign rightIdx = frame_posn - RIGHT_FIRST;

   // A strobe whose position is not the successor of the previous one is a
   // timing discontinuity, except for the very first strobe after reset,
   // which has nothing to compare against.
   assign discont = en && seenEn_q && (frame_posn != expectPosn_q);

   i2s_shift_in #(.WIDTH(WIDTH)) u_leftShift (
      .ck   (ck),
      .rst  (rst),
      .clr  (shiftClr),
      .shift(leftShift),
      .d    (sd),
      .q    (leftWord)
   );

   i2s_shift_in #(.WIDTH(WIDTH)) u_rightShift (
      .ck   (ck),
      .rst  (rst),
      .clr  (shiftClr),
      .shift(1'b0 | rightShift),
      .d    (sd),
      .q    (rightWord)
   );

   // State register.
   always_ff @(posedge ck) begin
      if (rst) begin
         state_q <= SYNC;
      end else begin
         state_q <= state_d;
      end
   end

   // Per-strobe actions of the alignment FSM. Losing alignment inside a frame
   // makes the same strobe behave as if the FSM were already waiting in SYNC,
   // so a jump that lands exactly on position 1 starts capturing immediately.
   always_comb begin
      lostAlign  = discont && ((state_q == LEFT) || (state_q == RIGHT));
      startFrame = en && (frame_posn == POSN_ONE) &&
                   (lostAlign || (state_q == SYNC) || (state_q == SYNC_WAIT));
      leftShift  = startFrame ||
                   (en && !lostAlign && (state_q == LEFT) && (leftIdx < WIDTH_P));
      leftDone   = en && !lostAlign && (state_q == LEFT) && (leftIdx == LAST_IDX);
      rightShift = en && !lostAlign && (state_q == RIGHT) && (rightIdx < WIDTH_P);
      rightDone  = rightShift && (rightIdx == LAST_IDX);
      shiftClr   = startFrame || lostAlign;
   end

   // Next-state logic. SYNC_WAIT re-arms on every frame start so back-to-back
   // frames are captured without a gap.
   always_comb begin
      state_d = state_q;
      if (lostAlign) begin
         state_d = startFrame ? LEFT : SYNC;
      end else begin
         case (state_q)
            SYNC, SYNC_WAIT: if (startFrame) state_d = LEFT;
            LEFT:            if (leftDone)   state_d = RIGHT;
            RIGHT:           if (rightDone)  state_d = SYNC_WAIT;
            default:         state_d = SYNC;
         endcase
      end
   end

   // Continuity tracker and the single-entry output register. A completed
   // pair is only loaded if the slot is empty or being emptied this cycle;
   // otherwise the presented pair is protected and the new one is dropped.
   // The right word is finished with the bit arriving on this very strobe.
   always_comb begin
      expectPosn_d = en ? nextPosn(frame_posn) : expectPosn_q;
      seenEn_d     = seenEn_q | en;
      loadPair     = rightDone && (!valid_q || ready);
      valid_d      = valid_q;
      if (loadPair) begin
         valid_d = 1'b1;
      end else if (valid_q && ready) begin
         valid_d = 1'b0;
      end
      leftOut_d  = loadPair ? leftWord : leftOut_q;
      rightOut_d = loadPair ? ((rightWord << 1) | WIDTH'(sd)) : rightOut_q;
      overrun_d  = rightDone && !loadPair;
      resync_d   = lostAlign;
   end

   // Datapath registers. Reset empties the output slot without any pulse.
   always_ff @(posedge ck) begin
      if (rst) begin
         expectPosn_q <= '0;
         seenEn_q     <= 1'b0;
         valid_q      <= 1'b0;
         overrun_q    <= 1'b0;
         resync_q     <= 1'b0;
         leftOut_q    <= '0;
         rightOut_q   <= '0;
      end else begin
         expectPosn_q <= expectPosn_d;
         seenEn_q     <= seenEn_d;
         valid_q      <= valid_d;
         overrun_q    <= overrun_d;
         resync_q     <= resync_d;
         leftOut_q    <= leftOut_d;
         rightOut_q   <= rightOut_d;
      end
   end

   assign left    = leftOut_q;
   assign right   = rightOut_q;
   assign valid   = valid_q;
   assign overrun = overrun_q;
   assign resync  = resync_q;

endmodule

// File: doc/i2s_stereo_rx.md
# i2s_stereo_rx

Deserialises one I2S data line into stereo sample pairs. It sits directly downstream of `i2s_dual` and consumes its `en` strobe and `frame_posn` count, whichever clock source `i2s_dual` has selected. It frame-aligns after reset or any timing discontinuity, for example an internal/external source switch. It delivers left and right words together over a valid/ready handshake.

## Interface
- `WIDTH`, 24: sample bits per channel, legal range 8..32, MSB first.
- `ck` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: one-`ck` strobe per SCK period from `i2s_dual`; `sd` is sampled only when `en`=1.
- `frame_posn` input 6: bit position in the 64-bit frame from `i2s_dual`.
  - 0..31 is the ws-low (left) half.
  - 32..63 is the ws-high (right) half.
- `sd` input 1: serial data, already synchronised to `ck`.
- `left` output WIDTH: left sample of the presented pair.
- `right` output WIDTH: right sample of the presented pair.
- `valid` output 1: a pair is presented.
- `ready` input 1: the consumer accepts the pair when `valid`&&`ready`.
- `overrun` output 1: one-`ck` pulse when a completed pair is dropped.
- `resync` output 1: one-`ck` pulse when alignment is lost and a partial frame is discarded.

## Operation
- Single clock. Reset is synchronous and active-high. Clock port is `ck`, reset port is `rst`.
- Everything below is evaluated only on `en`=1 cycles, except the handshake.
- Bit mapping uses the standard I2S one-bit delay.
  - Left bit k (k=0 is MSB) is at `frame_posn` = 1+k.
  - Right bit k is at (33+k) mod 64.
  - With WIDTH=32, the right LSB falls at posn 0 of the following frame.
  - Bits at all other positions are ignored.
- Continuity check: a register `expect` holds the previous posn+1 (mod 64). An `en` with `frame_posn`≠`expect` is a discontinuity. The first `en` after reset is never a discontinuity.
- States:
  - SYNC: wait for `en` with posn=1, capture left MSB, go to LEFT.
  - LEFT: shift in left bits. After left LSB, go to RIGHT.
  - RIGHT: shift in right bits. After right LSB, attempt output load, go to SYNC_WAIT.
  - SYNC_WAIT: wait for posn=1, then behave as in SYNC. This re-arms every frame without extra latency.
- Any discontinuity in LEFT or RIGHT:
  - Discard the partial left/right shift registers.
  - Pulse `resync`.
  - Go to SYNC.
  - The offending `en` cycle is itself examined as in SYNC: if its posn is 1, capture starts there.
- Discontinuity in SYNC or SYNC_WAIT: no pulse, no action.
- Output register, a single entry:
  - Load when the right LSB is captured and (`valid`=0 or `ready`=1). Set `valid`=1.
  - Otherwise drop the new pair and pulse `overrun`. The presented pair is unchanged.
  - Completion in the same cycle as a handshake loads the new pair; `valid` stays 1; no overrun.
  - Handshake with no completion: `valid`→0 next cycle. `left`/`right` hold their last values.
- `left`/`right` change only on a load.

## Timing
- Reset values:
  - `left`=0, `right`=0, `valid`=0, `overrun`=0, `resync`=0.
  - State is SYNC; shift registers and `expect` are cleared.
- Reset mid-frame: the partial frame is lost and the presented pair is lost, with no `overrun` or `resync` pulse.
- `sd` is registered in the same `ck` edge where `en`=1.
- Latency: `valid` (or `overrun`) rises 1 `ck` after the `en` cycle capturing the right LSB.
- `resync` is asserted 1 `ck` after the discontinuous `en`.
- `valid` must stay asserted, and `left`/`right` must stay stable, until accepted.
- Throughput is one pair per 64 `en` strobes. `ready` may be held low for up to 63 `en` periods without loss.

## Structure
- Shared package `i2s_pkg`:
  - `I2S_FRAME_BITS`=64
  - `I2S_POSN_W`=6
  - `I2S_HALF`=32
  - state encoding: SYNC, LEFT, RIGHT, SYNC_WAIT
- One sub-module `i2s_shift_in` (parameter WIDTH, ports `ck`, `rst`, `clr`, `shift`, `d`, `q`), instantiated once for left and once for right.
- Posn decode, continuity check, FSM and output register live in the top module.

## Test plan
- **Aligned stream:** WIDTH=24, `i2s_dual` running DIVIDER=16, model drives left=0xA5A5A5 and right=0x5A5A5A, `ready`=1 → first pair is exactly that, `valid` one `ck` after the right-LSB `en`, no pulses.
- **Mid-frame start:** release reset with posn=40 → no `valid` until a full frame starting at posn=1 completes; the first pair is correct.
- **Backpressure:** `ready`=0 for 2 frames → first pair held stable with `valid`=1; one `overrun` pulse at the second completion; after `ready`=1, the first pair is accepted and the third frame is presented.
- **Simultaneous:** `ready` rises exactly on the completion cycle → new pair loaded, `valid` stays 1, no `overrun`.
- **Source switch:** jump posn from 10 to 50 during LEFT (mimics `i2s_dual` toggling `external`) → one `resync` pulse, no `valid` for the partial frame, correct pairs resume from the next posn=1.
- **WIDTH=32:** right LSB at posn 0 of the next frame → pair 0xFFFF0001/0x8000FFFE correct, continuity wraps 63→0 without `resync`.
